// File: rtl/count_limit_monitor.sv
// Purpose: passive observer of an up/down counter; flags wraps, tallies them, raises sticky window alarms.
// Latency: 1 clk edge from the sampled count/mode/limits to every registered output.
// Backpressure: none; samples every edge and never drives the counter.
module count_limit_monitor #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    input  logic             ack,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic [CW-1:0]    wrap_cnt,
    output logic             alarm_hi,
    output logic             alarm_lo,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        IN_WIN,
        QUAL_HI,
        ALM_HI,
        QUAL_LO,
        ALM_LO
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [CW-1:0]    WCNT_MAX = {CW{1'b1}};
    localparam logic [7:0]       HOLD_Q   = 8'(HOLD);
    localparam bit               HOLD_ONE = (HOLD == 1);

    state_t           state;
    logic [7:0]       qcnt;
    logic [WIDTH-1:0] prev_count;
    logic             prev_vld;

    logic             above;
    logic             below;
    logic             cfg_bad;
    logic             up_ev;
    logic             dn_ev;
    logic             qual_done;

    // Combinational classification of the current sample against the window and the previous sample.
    always_comb begin
        above     = 1'b0;
        below     = 1'b0;
        cfg_bad   = 1'b0;
        up_ev     = 1'b0;
        dn_ev     = 1'b0;
        qual_done = 1'b0;
        above     = count > hi_lim;
        below     = count < lo_lim;
        cfg_bad   = lo_lim > hi_lim;
        // Direction must match the jump, otherwise it is a load, not a wrap.
        up_ev     = prev_vld && (prev_count == CNT_MAX) && (count == '0) && mode;
        dn_ev     = prev_vld && (prev_count == '0) && (count == CNT_MAX) && !mode;
        qual_done = (qcnt + 8'd1) == HOLD_Q;
    end

    // Wrap detection, saturating wrap tally and registered config error.
    always_ff @(posedge clk) begin
        if (clr) begin
            prev_count <= '0;
            prev_vld   <= 1'b0;
            wrap_up    <= 1'b0;
            wrap_dn    <= 1'b0;
            wrap_cnt   <= '0;
            cfg_err    <= 1'b0;
        end else begin
            prev_count <= count;
            prev_vld   <= 1'b1;
            wrap_up    <= up_ev;
            wrap_dn    <= dn_ev;
            cfg_err    <= cfg_bad;
            // ack restarts the tally, but a wrap on the same edge is still counted.
            if (ack) begin
                wrap_cnt <= (up_ev || dn_ev) ? CW'(1) : '0;
            end else if ((up_ev || dn_ev) && (wrap_cnt != WCNT_MAX)) begin
                wrap_cnt <= wrap_cnt + CW'(1);
            end
        end
    end

    // Window qualification FSM with sticky alarms released only by ack outside the offending side.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IN_WIN;
            qcnt     <= 8'd0;
            alarm_hi <= 1'b0;
            alarm_lo <= 1'b0;
        end else if (cfg_bad) begin
            state    <= IN_WIN;
            qcnt     <= 8'd0;
            alarm_hi <= 1'b0;
            alarm_lo <= 1'b0;
        end else begin
            case (state)
                IN_WIN: begin
                    if (above) begin
                        state    <= HOLD_ONE ? ALM_HI : QUAL_HI;
                        qcnt     <= HOLD_ONE ? 8'd0 : 8'd1;
                        alarm_hi <= HOLD_ONE;
                        alarm_lo <= 1'b0;
                    end else if (below) begin
                        state    <= HOLD_ONE ? ALM_LO : QUAL_LO;
                        qcnt     <= HOLD_ONE ? 8'd0 : 8'd1;
                        alarm_hi <= 1'b0;
                        alarm_lo <= HOLD_ONE;
                    end else begin
                        qcnt     <= 8'd0;
                        alarm_hi <= 1'b0;
                        alarm_lo <= 1'b0;
                    end
                end
                QUAL_HI: begin
                    alarm_lo <= 1'b0;
                    if (above && qual_done) begin
                        state    <= ALM_HI;
                        qcnt     <= 8'd0;
                        alarm_hi <= 1'b1;
                    end else if (above) begin
                        qcnt     <= qcnt + 8'd1;
                        alarm_hi <= 1'b0;
                    end else if (below) begin
                        state    <= QUAL_LO;
                        qcnt     <= 8'd1;
                        alarm_hi <= 1'b0;
                    end else begin
                        state    <= IN_WIN;
                        qcnt     <= 8'd0;
                        alarm_hi <= 1'b0;
                    end
                end
                QUAL_LO: begin
                    alarm_hi <= 1'b0;
                    if (below && qual_done) begin
                        state    <= ALM_LO;
                        qcnt     <= 8'd0;
                        alarm_lo <= 1'b1;
                    end else if (below) begin
                        qcnt     <= qcnt + 8'd1;
                        alarm_lo <= 1'b0;
                    end else if (above) begin
                        state    <= QUAL_HI;
                        qcnt     <= 8'd1;
                        alarm_lo <= 1'b0;
                    end else begin
                        state    <= IN_WIN;
                        qcnt     <= 8'd0;
                        alarm_lo <= 1'b0;
                    end
                end
                ALM_HI: begin
                    qcnt     <= 8'd0;
                    alarm_lo <= 1'b0;
                    alarm_hi <= 1'b1;
                    if (!above && ack) begin
                        alarm_hi <= 1'b0;
                        if (below) begin
                            state    <= HOLD_ONE ? ALM_LO : QUAL_LO;
                            qcnt     <= HOLD_ONE ? 8'd0 : 8'd1;
                            alarm_lo <= HOLD_ONE;
                        end else begin
                            state <= IN_WIN;
                        end
                    end
                end
                ALM_LO: begin
                    qcnt     <= 8'd0;
                    alarm_hi <= 1'b0;
                    alarm_lo <= 1'b1;
                    if (!below && ack) begin
                        alarm_lo <= 1'b0;
                        if (above) begin
                            state    <= HOLD_ONE ? ALM_HI : QUAL_HI;
                            qcnt     <= HOLD_ONE ? 8'd0 : 8'd1;
                            alarm_hi <= HOLD_ONE;
                        end else begin
                            state <= IN_WIN;
                        end
                    end
                end
                default: begin
                    state    <= IN_WIN;
                    qcnt     <= 8'd0;
                    alarm_hi <= 1'b0;
                    alarm_lo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_limit_monitor.sv
// Directed bench for count_limit_monitor with an expected-output queue.
// Each step pushes the expected outputs, the edge is taken, then outputs are popped and compared.
module tb_count_limit_monitor;

    logic       clk;
    logic       clr;
    logic [7:0] count;
    logic       mode;
    logic [7:0] lo_lim;
    logic [7:0] hi_lim;
    logic       ack;
    logic       wrap_up;
    logic       wrap_dn;
    logic [7:0] wrap_cnt;
    logic       alarm_hi;
    logic       alarm_lo;
    logic       cfg_err;

    typedef struct packed {
        logic       wu;
        logic       wd;
        logic [7:0] wc;
        logic       ah;
        logic       al;
        logic       cfg;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   exp_wc;

    count_limit_monitor #(.WIDTH(8), .HOLD(4), .CW(8)) dut (
        .clk      (clk),
        .clr      (clr),
        .count    (count),
        .mode     (mode),
        .lo_lim   (lo_lim),
        .hi_lim   (hi_lim),
        .ack      (ack),
        .wrap_up  (wrap_up),
        .wrap_dn  (wrap_dn),
        .wrap_cnt (wrap_cnt),
        .alarm_hi (alarm_hi),
        .alarm_lo (alarm_lo),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one sample, queue what the outputs must be after the edge, then compare.
    task automatic step(input logic [7:0] c, input logic m, input logic a, input logic r,
                        input logic ewu, input logic ewd, input logic eah, input logic eal);
        exp_t e;
        @(negedge clk);
        count = c;
        mode  = m;
        ack   = a;
        clr   = r;
        if (r) begin
            exp_wc = 0;
        end else if (a) begin
            exp_wc = (ewu || ewd) ? 1 : 0;
        end else if ((ewu || ewd) && exp_wc < 255) begin
            exp_wc = exp_wc + 1;
        end
        e.wu  = ewu;
        e.wd  = ewd;
        e.wc  = 8'(exp_wc);
        e.ah  = eah;
        e.al  = eal;
        e.cfg = !r && (lo_lim > hi_lim);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            check("wrap_up",  32'(wrap_up),  32'(e.wu));
            check("wrap_dn",  32'(wrap_dn),  32'(e.wd));
            check("wrap_cnt", 32'(wrap_cnt), 32'(e.wc));
            check("alarm_hi", 32'(alarm_hi), 32'(e.ah));
            check("alarm_lo", 32'(alarm_lo), 32'(e.al));
            check("cfg_err",  32'(cfg_err),  32'(e.cfg));
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        exp_wc = 0;
        clr    = 1'b1;
        count  = 8'd0;
        mode   = 1'b1;
        ack    = 1'b0;
        lo_lim = 8'd0;
        hi_lim = 8'd255;

        // Reset state
        step(8'd0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
        step(8'd0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);

        // Up-wrap: 253,254,255,0,1 counting up; first sample after clr has no history
        step(8'd253, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd254, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd255, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd0,   1'b1, 1'b0, 1'b0, 1, 0, 0, 0);
        step(8'd1,   1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

        // Down-wrap: 2,1,0,255 counting down
        step(8'd2,   1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd1,   1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd0,   1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd255, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0);

        // Jumps with the wrong direction are loads, not wraps
        step(8'd0,   1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd255, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

        // High alarm qualification on 201..204, ack while above is ignored
        lo_lim = 8'd10;
        hi_lim = 8'd200;
        step(8'd199, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd200, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd201, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd202, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd203, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd204, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0);
        step(8'd205, 1'b1, 1'b1, 1'b0, 0, 0, 1, 0);
        for (int i = 206; i <= 210; i++) begin
            step(8'(i), 1'b1, 1'b0, 1'b0, 0, 0, 1, 0);
        end
        // Sticky after re-entering the window, released by ack
        step(8'd150, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0);
        step(8'd150, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);

        // Qualification abort; restart leaves count at 1 so three more above samples alarm
        step(8'd201, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd202, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd203, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd150, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd201, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd202, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd203, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd204, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0);
        step(8'd150, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);

        // Low alarm, then clr mid-alarm with 255 -> 0 across it
        step(8'd9,   1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd8,   1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd7,   1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd6,   1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
        step(8'd255, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
        step(8'd0,   1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

        // Inverted window: cfg_err, no alarms, wraps still detected
        lo_lim = 8'd100;
        hi_lim = 8'd50;
        for (int i = 0; i < 5; i++) begin
            step(8'd20, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        end
        step(8'd0,   1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd255, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0);
        lo_lim = 8'd10;
        hi_lim = 8'd200;
        step(8'd100, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

        // Saturation: 260 up-wraps hold the tally at 255
        lo_lim = 8'd0;
        hi_lim = 8'd255;
        for (int i = 0; i < 260; i++) begin
            step(8'd255, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
            step(8'd0,   1'b1, 1'b0, 1'b0, 1, 0, 0, 0);
        end
        // ack with a simultaneous wrap leaves 1, ack alone clears to 0
        step(8'd255, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(8'd0,   1'b1, 1'b1, 1'b0, 1, 0, 0, 0);
        step(8'd5,   1'b1, 1'b1, 1'b0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
